// File: rtl/cpa_accumulator.sv
// cpa_accumulator: resolves redundant sum/carry rows with a CPA, then accumulates
// first/last-framed groups into a signed result behind valid/ready handshakes.
module cpa_accumulator #(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 40,
    parameter int CNT_WIDTH = 16,
    parameter int SATURATE  = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [WIDTH-1:0]     in_sum_i,
    input  logic [WIDTH-1:0]     in_carry_i,
    input  logic                 in_first_i,
    input  logic                 in_last_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [ACC_WIDTH-1:0] out_data_o,
    output logic                 out_overflow_o,
    output logic [CNT_WIDTH-1:0] out_count_o
);
    localparam int MSB = ACC_WIDTH - 1;

    logic                 s1_valid, s1_first, s1_last, s2_fire;
    logic [ACC_WIDTH-1:0] s1_p, acc, base, sum, nxt_acc;
    logic [WIDTH-1:0]     p_raw;
    logic                 ovf, of, nxt_ovf;
    logic [CNT_WIDTH-1:0] cnt, nxt_cnt;

    // Last beats wait for the output register; non-last beats never do.
    assign s2_fire    = s1_valid && (!s1_last || !out_valid_o || out_ready_i);
    assign in_ready_o = !s1_valid || s2_fire;
    assign p_raw      = in_sum_i + in_carry_i;

    always_comb begin
        base    = s1_first ? '0 : acc;
        sum     = base + s1_p;
        of      = (base[MSB] == s1_p[MSB]) && (sum[MSB] != base[MSB]);
        nxt_acc = (of && SATURATE != 0) ? {base[MSB], {MSB{!base[MSB]}}} : sum;
        nxt_ovf = (!s1_first && ovf) || of;
        nxt_cnt = s1_first ? CNT_WIDTH'(1) : (&cnt ? cnt : cnt + CNT_WIDTH'(1));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid       <= 1'b0;
            s1_first       <= 1'b0;
            s1_last        <= 1'b0;
            s1_p           <= '0;
            acc            <= '0;
            ovf            <= 1'b0;
            cnt            <= '0;
            out_valid_o    <= 1'b0;
            out_data_o     <= '0;
            out_overflow_o <= 1'b0;
            out_count_o    <= '0;
        end else begin
            if (in_ready_o)
                s1_valid <= in_valid_i;
            if (in_valid_i && in_ready_o) begin
                s1_p     <= ACC_WIDTH'($signed(p_raw));
                s1_first <= in_first_i;
                s1_last  <= in_last_i;
            end
            if (s2_fire) begin
                acc <= nxt_acc;
                ovf <= nxt_ovf;
                cnt <= nxt_cnt;
            end
            if (s2_fire && s1_last) begin
                out_valid_o    <= 1'b1;
                out_data_o     <= nxt_acc;
                out_overflow_o <= nxt_ovf;
                out_count_o    <= nxt_cnt;
            end else if (out_ready_i) begin
                out_valid_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_cpa_accumulator.sv
// tb_cpa_accumulator: directed and randomized checks of cpa_accumulator against
// an arithmetic group-sum model, including 17-bit saturating and wrapping variants.
module tb_cpa_accumulator;
    logic        clk = 0, rst = 1;
    logic        in_valid = 0, in_first = 0, in_last = 0, out_ready = 1;
    logic [15:0] in_sum = 0, in_carry = 0;
    logic        in_ready, out_valid, out_ovf;
    logic [39:0] out_data;
    logic [15:0] out_cnt;
    logic        ready_s, valid_s, ovf_s, ready_w, valid_w, ovf_w;
    logic [16:0] data_s, data_w;
    logic [15:0] cnt_s, cnt_w;

    int n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    cpa_accumulator #(.WIDTH(16), .ACC_WIDTH(40), .CNT_WIDTH(16), .SATURATE(0)) dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_sum_i(in_sum), .in_carry_i(in_carry), .in_first_i(in_first), .in_last_i(in_last),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .out_overflow_o(out_ovf), .out_count_o(out_cnt));

    cpa_accumulator #(.WIDTH(16), .ACC_WIDTH(17), .CNT_WIDTH(16), .SATURATE(1)) dut_s (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(ready_s),
        .in_sum_i(in_sum), .in_carry_i(in_carry), .in_first_i(in_first), .in_last_i(in_last),
        .out_valid_o(valid_s), .out_ready_i(out_ready), .out_data_o(data_s),
        .out_overflow_o(ovf_s), .out_count_o(cnt_s));

    cpa_accumulator #(.WIDTH(16), .ACC_WIDTH(17), .CNT_WIDTH(16), .SATURATE(0)) dut_w (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(ready_w),
        .in_sum_i(in_sum), .in_carry_i(in_carry), .in_first_i(in_first), .in_last_i(in_last),
        .out_valid_o(valid_w), .out_ready_i(out_ready), .out_data_o(data_w),
        .out_overflow_o(ovf_w), .out_count_o(cnt_w));

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: exact integer sum per group, then clamp or wrap into aw bits.
    typedef struct {
        longint d0, d1, d2;
        bit     o0, o1, o2;
        int     c;
    } res_t;

    res_t   exp_q[$];
    longint m_acc[3];
    bit     m_ovf[3];
    int     m_cnt;

    function automatic longint fold(input longint v, input int aw, input bit sat, output bit of);
        longint mx = (longint'(1) <<< (aw - 1)) - 1;
        longint mn = -mx - 1;
        of = (v > mx) || (v < mn);
        if (!of) return v;
        if (sat) return (v > mx) ? mx : mn;
        return (v > mx) ? v - 2 * (mx + 1) : v + 2 * (mx + 1);
    endfunction

    logic signed [15:0] ps;
    bit     mof, prev_hold = 0;
    longint prev_data, base;
    int     prev_cnt;
    res_t   r, e;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            for (int k = 0; k < 3; k++) begin
                m_acc[k] = 0;
                m_ovf[k] = 0;
            end
            m_cnt = 0;
            prev_hold = 0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", longint'($signed(out_data)), prev_data);
                check("hold_cnt", out_cnt, prev_cnt);
            end
            check("ready_sat_vs_main", ready_s, in_ready);
            check("ready_wrap_vs_main", ready_w, in_ready);
            check("valid_sat_vs_main", valid_s, out_valid);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("unexpected_result", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("res_data", longint'($signed(out_data)), e.d0);
                    check("res_ovf", out_ovf, e.o0);
                    check("res_cnt", out_cnt, e.c);
                    check("res_data_sat", longint'($signed(data_s)), e.d1);
                    check("res_ovf_sat", ovf_s, e.o1);
                    check("res_data_wrap", longint'($signed(data_w)), e.d2);
                    check("res_ovf_wrap", ovf_w, e.o2);
                    check("res_cnt_wrap", cnt_w, e.c);
                end
            end
            if (in_valid && in_ready) begin
                ps = in_sum + in_carry;
                for (int k = 0; k < 3; k++) begin
                    base = in_first ? 0 : m_acc[k];
                    m_acc[k] = fold(base + longint'(ps), (k == 0) ? 40 : 17, k == 1, mof);
                    m_ovf[k] = (!in_first && m_ovf[k]) || mof;
                end
                m_cnt = in_first ? 1 : (m_cnt < 65535 ? m_cnt + 1 : m_cnt);
                if (in_last) begin
                    r.d0 = m_acc[0]; r.d1 = m_acc[1]; r.d2 = m_acc[2];
                    r.o0 = m_ovf[0]; r.o1 = m_ovf[1]; r.o2 = m_ovf[2];
                    r.c = m_cnt;
                    exp_q.push_back(r);
                end
            end
            prev_hold = out_valid && !out_ready;
        end
        prev_data = longint'($signed(out_data));
        prev_cnt = int'(out_cnt);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] s, input logic [15:0] c, input logic f, input logic l);
        int n = 0;
        in_valid = 1; in_sum = s; in_carry = c; in_first = f; in_last = l;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            if (++n > 50) begin
                check("send_timeout", 0, 1);
                break;
            end
        end
        step();
        in_valid = 0; in_first = 0; in_last = 0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        forever begin
            @(negedge clk);
            if (out_valid) break;
            if (++n > 50) begin
                check(tag, 0, 1);
                break;
            end
        end
    endtask

    task automatic expect_out(input string tag, input longint d, input int c, input bit o);
        wait_valid({tag, "_timeout"});
        check({tag, "_data"}, longint'($signed(out_data)), d);
        check({tag, "_cnt"}, out_cnt, c);
        check({tag, "_ovf"}, out_ovf, o);
        step();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_ovf", out_ovf, 0);
        check("rst_out_cnt", out_cnt, 0);
        step();
        rst = 0;
        step();

        send(16'h0003, 16'h0004, 1, 1);
        @(negedge clk);
        check("t1_valid_t1", out_valid, 0);
        @(negedge clk);
        check("t1_valid_t2", out_valid, 1);
        check("t1_data", out_data, 7);
        check("t1_cnt", out_cnt, 1);
        check("t1_ovf", out_ovf, 0);
        step();

        send(16'hFFFF, 16'h0001, 1, 1);
        expect_out("t2_zero", 0, 1, 0);
        send(16'h8000, 16'h0000, 1, 1);
        expect_out("t2_neg", -32768, 1, 0);
        check("t2_raw", out_data, 40'hFF_FFFF_8000);

        in_valid = 1; in_sum = 600; in_carry = 400;
        for (int i = 0; i < 4; i++) begin
            in_first = (i == 0);
            in_last = (i == 3);
            @(negedge clk);
            check("t3_ready", in_ready, 1);
            step();
        end
        in_valid = 0; in_first = 0; in_last = 0;
        expect_out("t3", 4000, 4, 0);

        send(16'h4000, 16'h3FFF, 1, 0);
        send(16'h7FFF, 16'h0000, 0, 0);
        send(16'h7FFF, 16'h0000, 0, 1);
        wait_valid("t4_timeout");
        check("t4_sat_data", longint'($signed(data_s)), 65535);
        check("t4_sat_ovf", ovf_s, 1);
        check("t4_wrap_data", longint'($signed(data_w)), -32771);
        check("t4_wrap_ovf", ovf_w, 1);
        check("t4_main_data", out_data, 98301);
        check("t4_main_ovf", out_ovf, 0);
        step();

        out_ready = 0;
        send(16'd11, 16'd0, 1, 1);
        wait_valid("t5_pending_timeout");
        step();
        send(16'd1, 16'd0, 1, 0);
        send(16'd2, 16'd0, 0, 0);
        send(16'd3, 16'd0, 0, 1);
        in_valid = 1; in_sum = 20; in_carry = 0; in_first = 1; in_last = 1;
        repeat (3) begin
            @(negedge clk);
            check("t5_stall_ready", in_ready, 0);
            check("t5_stall_valid", out_valid, 1);
            check("t5_stall_data", out_data, 11);
            step();
        end
        out_ready = 1;
        @(negedge clk);
        check("t5_release_ready", in_ready, 1);
        check("t5_old_data", out_data, 11);
        step();
        in_valid = 0; in_first = 0; in_last = 0;
        @(negedge clk);
        check("t5_new_valid", out_valid, 1);
        check("t5_new_data", out_data, 6);
        check("t5_new_cnt", out_cnt, 3);
        @(negedge clk);
        check("t5_next_data", out_data, 20);
        check("t5_next_cnt", out_cnt, 1);
        step();

        send(16'd7, 16'd0, 1, 0);
        send(16'd8, 16'd0, 0, 0);
        rst = 1;
        step();
        rst = 0;
        repeat (4) begin
            @(negedge clk);
            check("t6_no_output", out_valid, 0);
        end
        step();
        send(16'd2, 16'd3, 1, 1);
        expect_out("t6", 5, 1, 0);

        begin
            bit took;
            for (int n = 0; n < 3000; n++) begin
                @(negedge clk);
                took = in_valid && in_ready;
                step();
                if (!in_valid || took) begin
                    in_valid = ($urandom_range(3) != 0);
                    in_sum = 16'($urandom);
                    in_carry = 16'($urandom);
                    in_first = ($urandom_range(2) == 0);
                    in_last = ($urandom_range(2) == 0);
                end
                out_ready = ($urandom_range(3) != 0);
            end
        end
        in_valid = 0; in_first = 0; in_last = 0; out_ready = 1;
        repeat (10) step();
        check("drain_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
